// File: rtl/jts16b_snd_romarb.sv
// Sound-ROM arbiter for the S16B sound board.
// Shares one SDRAM port between Z80 fetches and uPD7759 sample fetches.
// Each requester keeps a one-entry cache, so a held address reads with no
// new access. Ties are broken round-robin, and a watchdog aborts any access
// whose rom_ok never arrives.
module jts16b_snd_romarb #(
    parameter int          PCM_AW   = 17,
    parameter logic [18:0] PCM_BASE = 19'h20000,
    parameter logic [7:0]  TOUT     = 8'd200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_cs,
    input  logic [18:0]       cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_ok,
    input  logic              pcm_cs,
    input  logic [PCM_AW-1:0] pcm_addr,
    output logic [7:0]        pcm_data,
    output logic              pcm_ok,
    output logic              rom_cs,
    output logic [18:0]       rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic              tout
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT} state_t;

    // Owner/last encoding: 0 = CPU, 1 = PCM
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_PCM = 1'b1;

    state_t            state;
    logic              owner, last;
    logic [18:0]       lat_addr;
    logic [7:0]        wdog;
    logic [18:0]       cpu_tag;
    logic              cpu_vld;
    logic [PCM_AW-1:0] pcm_tag;
    logic              pcm_vld;

    logic        cpu_hit, pcm_hit, cpu_req, pcm_req, grant_pcm;
    logic [18:0] pcm_ext, pcm_rom;
    logic [7:0]  wdog_nx;

    assign cpu_hit = cpu_cs & cpu_vld & (cpu_addr == cpu_tag);
    assign pcm_hit = pcm_cs & pcm_vld & (pcm_addr == pcm_tag);
    assign cpu_ok  = cpu_hit;
    assign pcm_ok  = pcm_hit;
    assign cpu_req = cpu_cs & ~cpu_hit;
    assign pcm_req = pcm_cs & ~pcm_hit;

    // PCM samples live at an offset inside the sound ROM; the carry wraps
    assign pcm_ext = 19'(pcm_addr);
    assign pcm_rom = PCM_BASE + pcm_ext;

    // PCM wins when alone, or on a tie when the CPU was served last
    assign grant_pcm = pcm_req & (~cpu_req | (last == OWN_CPU));
    assign wdog_nx   = wdog + 8'd1;

    // Arbitration FSM, SDRAM request and cache fills
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= OWN_CPU;
            last     <= OWN_PCM;
            lat_addr <= '0;
            wdog     <= '0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            tout     <= 1'b0;
            cpu_tag  <= '0;
            cpu_vld  <= 1'b0;
            cpu_data <= '0;
            pcm_tag  <= '0;
            pcm_vld  <= 1'b0;
            pcm_data <= '0;
        end else begin
            tout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req | pcm_req) begin
                        owner    <= grant_pcm;
                        rom_addr <= grant_pcm ? pcm_rom : cpu_addr;
                        lat_addr <= grant_pcm ? pcm_ext : cpu_addr;
                        rom_cs   <= 1'b1;
                        wdog     <= '0;
                        state    <= S_SETTLE;
                    end
                end
                // rom_ok here may still belong to the previous address
                S_SETTLE: state <= S_WAIT;
                S_WAIT: begin
                    if (rom_ok) begin
                        if (owner == OWN_PCM) begin
                            pcm_data <= rom_data;
                            pcm_tag  <= lat_addr[PCM_AW-1:0];
                            pcm_vld  <= 1'b1;
                        end else begin
                            cpu_data <= rom_data;
                            cpu_tag  <= lat_addr;
                            cpu_vld  <= 1'b1;
                        end
                        rom_cs <= 1'b0;
                        last   <= owner;
                        state  <= S_IDLE;
                    end else begin
                        wdog <= wdog_nx;
                        if (wdog_nx == TOUT) begin
                            rom_cs <= 1'b0;
                            tout   <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    rom_cs <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jts16b_snd_romarb.sv
// Directed bench for the sound-ROM arbiter with a small SDRAM stand-in.
module tb_jts16b_snd_romarb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cs, pcm_cs, rom_cs, rom_ok, tout, cpu_ok, pcm_ok;
    logic [18:0] cpu_addr, rom_addr;
    logic [16:0] pcm_addr;
    logic [7:0]  cpu_data, pcm_data, rom_data;

    // SDRAM stand-in controls
    logic       sd_on, stuck_ok;
    int         sd_delay, sd_cnt;
    logic [7:0] sd_val;

    int total = 0;
    int bad   = 0;

    jts16b_snd_romarb #(.PCM_AW(17), .PCM_BASE(19'h20000), .TOUT(8'd8)) dut (
        .clk(clk), .rst(rst),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
        .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .tout(tout)
    );

    always #5 clk = ~clk;

    // Cycles since rom_cs rose; data answers after sd_delay of them
    always @(posedge clk) sd_cnt <= rom_cs ? sd_cnt + 1 : 0;
    assign rom_ok   = stuck_ok | (rom_cs & sd_on & (sd_cnt >= sd_delay));
    assign rom_data = sd_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ok(input logic pcm, input int lim);
        int n;
        n = 0;
        while (!(pcm ? pcm_ok : cpu_ok) && n < lim) begin
            tick();
            n++;
        end
        chk(pcm ? "pcm_ok_wait" : "cpu_ok_wait", pcm ? pcm_ok : cpu_ok, 1);
    endtask

    initial begin
        int n;
        rst = 1; cpu_cs = 1; cpu_addr = 19'h00010; pcm_cs = 0; pcm_addr = '0;
        sd_on = 1; stuck_ok = 0; sd_delay = 0; sd_val = 8'h33; sd_cnt = 0;

        // Reset held two cycles with a CPU request pending
        tick();
        chk("rst_cpu_ok", cpu_ok, 0);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_cpu_data", cpu_data, 8'h00);
        chk("rst_tout", tout, 0);
        tick();
        chk("rst_rom_cs2", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 19'h0);
        rst = 0;
        tick();
        chk("first_rom_cs", rom_cs, 1);
        wait_ok(0, 20);
        chk("first_data", cpu_data, 8'h33);

        // CPU miss, SDRAM answers after 5 cycles, then 20 cycles of hits
        cpu_addr = 19'h01234; sd_delay = 5; sd_val = 8'h5A;
        tick();
        chk("miss_rom_cs", rom_cs, 1);
        chk("miss_rom_addr", rom_addr, 19'h01234);
        tick(5);
        chk("miss_not_yet", cpu_ok, 0);
        tick();
        chk("miss_ok", cpu_ok, 1);
        chk("miss_data", cpu_data, 8'h5A);
        chk("miss_cs_low", rom_cs, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rom_cs) n++;
        end
        chk("hit_no_cs", n, 0);
        chk("hit_ok", cpu_ok, 1);
        cpu_cs = 0;

        // PCM mapping at top and bottom of the PCM range
        pcm_cs = 1; pcm_addr = 17'h1FFFF; sd_delay = 1; sd_val = 8'hC3;
        tick();
        chk("pcm_top_addr", rom_addr, 19'h3FFFF);
        wait_ok(1, 20);
        chk("pcm_top_data", pcm_data, 8'hC3);
        pcm_addr = 17'h0; sd_val = 8'h3C;
        tick();
        chk("pcm_bot_addr", rom_addr, 19'h20000);
        wait_ok(1, 20);
        chk("pcm_bot_data", pcm_data, 8'h3C);
        pcm_cs = 0;

        // Tie after reset: CPU first, then PCM
        rst = 1;
        tick();
        rst = 0;
        cpu_cs = 1; cpu_addr = 19'h00100; pcm_cs = 1; pcm_addr = 17'h00200;
        sd_delay = 2; sd_val = 8'h77;
        tick();
        chk("tie1_cpu_first", rom_addr, 19'h00100);
        wait_ok(0, 20);
        tick();
        chk("tie1_pcm_next", rom_addr, 19'h20200);
        wait_ok(1, 20);
        // Next tie: last was PCM, so CPU again
        cpu_addr = 19'h00101; pcm_addr = 17'h00201;
        tick();
        chk("tie2_cpu_first", rom_addr, 19'h00101);
        wait_ok(0, 20);
        wait_ok(1, 20);
        // CPU alone, then a tie: last is CPU, so PCM wins
        cpu_addr = 19'h00102;
        tick();
        chk("solo_cpu", rom_addr, 19'h00102);
        wait_ok(0, 20);
        cpu_addr = 19'h00103; pcm_addr = 17'h00203;
        tick();
        chk("tie3_pcm_first", rom_addr, 19'h20203);
        wait_ok(1, 20);
        wait_ok(0, 20);
        pcm_cs = 0;

        // rom_ok held high: the SETTLE-cycle value must be ignored
        stuck_ok = 1; sd_on = 0; sd_val = 8'h11; cpu_addr = 19'h00400;
        tick();
        chk("stale_cs", rom_cs, 1);
        tick();
        chk("stale_ignored", cpu_ok, 0);
        sd_val = 8'h22;
        tick();
        chk("stale_ok", cpu_ok, 1);
        chk("stale_data", cpu_data, 8'h22);
        stuck_ok = 0;

        // Watchdog: no rom_ok, SETTLE plus 8 WAIT cycles, then abort
        cpu_addr = 19'h00500;
        tick();
        n = 0;
        while (rom_cs && n < 50) begin
            n++;
            tick();
        end
        chk("wd_cs_cycles", n, 9);
        chk("wd_tout", tout, 1);
        chk("wd_cs_low", rom_cs, 0);
        chk("wd_no_ok", cpu_ok, 0);
        tick();
        chk("wd_tout_pulse", tout, 0);
        chk("wd_reissue", rom_cs, 1);
        chk("wd_reissue_addr", rom_addr, 19'h00500);
        sd_on = 1; sd_delay = 0; sd_val = 8'h99;
        wait_ok(0, 20);
        chk("wd_data", cpu_data, 8'h99);

        // Reset mid-access drops rom_cs and invalidates caches
        sd_on = 0; pcm_cs = 1; pcm_addr = 17'h00010;
        tick();
        chk("mid_cs", rom_cs, 1);
        rst = 1;
        tick();
        chk("mid_rst_cs", rom_cs, 0);
        chk("mid_rst_cpu_ok", cpu_ok, 0);
        rst = 0; pcm_cs = 0; cpu_cs = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
